inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Fetch stage directly upstream of the distributed-RAM instruction memory.
//  - Owns the program counter and drives the memory's word-addressed read port.
//  - Captures the same-cycle (combinational) read data.
//  - Buffers fetched {pc, inst} pairs in a small queue feeding decode.
//  - Decode back-pressure and branch/jump redirects are absorbed here.
// PARAMETERS
//  ADDR_W    32  width of PC / imem read address (word address, not byte)
//  RESET_PC  0   PC value loaded on reset
//  DEPTH     2   fetch-queue entries (power of 2, >=2)
// PORTS
//  clk             in   1       core clock; all state updates on posedge
//  rstn            in   1       synchronous reset, active-low
//  imem_ra         out  ADDR_W  read address to instruction memory (== pc)
//  imem_rd         in   32      instruction word, valid in the same cycle as imem_ra
//  redirect_valid  in   1       branch/jump taken; flush the queue and reload the PC
//  redirect_pc     in   ADDR_W  new word-address PC for the redirect
//  id_ready        in   1       decode accepts the head entry this cycle
//  id_valid        out  1       head entry valid (queue not empty)
//  id_inst         out  32      head instruction; 0 when !id_valid
//  id_pc           out  ADDR_W  PC of head instruction; 0 when !id_valid
// BEHAVIOUR
//  Reset (rstn==0 at posedge):
//    - pc=RESET_PC; queue empty; id_valid=0, id_inst=0, id_pc=0.
//    - Counters (if enabled) = 0.
//  imem_ra = pc, purely from the pc register (no combinational path from inputs).
//  pop  = id_valid & id_ready.
//  push = !redirect_valid & (count<DEPTH | pop).
//  Redirect cycle (highest priority):
//    - Queue cleared.
//    - pc<=redirect_pc.
//    - No push; the head is discarded even if popped.
//    - First redirected entry is visible at id_valid in the next cycle.
//  Otherwise:
//    - push: enqueue {pc, imem_rd}; pc<=pc+1, wrapping modulo 2^ADDR_W.
//    - No push: pc holds.
//  Full & pop in the same cycle: push allowed; count unchanged; order preserved.
//  Empty & no pop: the push lands and is presented next cycle (latency: 1 cycle pc->id_valid).
//  Queue order is strict FIFO. id_* are driven from the head register (registered outputs).
//  Redirect with rstn==0: reset wins.
//  Reset mid-stream discards all queued entries.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    - Adds out ports perf_fetched[31:0] and perf_bubbles[31:0].
//    - perf_fetched increments on every push.
//    - perf_bubbles increments on every cycle with !id_valid & !redirect_valid.
//    - Both counters saturate at 32'hFFFF_FFFF.
//    - Both counters are cleared only by reset.
//  FETCH_PERF_EN undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  Package core_pkg:
//    - ADDR_W default.
//    - RESET_PC default.
//    - fetch_entry_t {pc[ADDR_W-1:0], inst[31:0]}.
//    - INST_NOP = 32'h0.
//  Sub-module fetch_queue:
//    - DEPTH-entry FIFO of fetch_entry_t.
//    - Ports: push, pop, flush, count, head.
//    - flush has priority over push.
//  Top: pc register, push/pop control, optional perf counters.
// TESTING
//  1. Reset, id_ready=1 held, memory words i -> 32'h1000+i:
//     id_pc=0,1,2,... on consecutive cycles from cycle 1; id_inst=32'h1000+id_pc.
//  2. id_ready=0 for 5 cycles:
//     - Queue fills to DEPTH; pc stops at RESET_PC+DEPTH; id_pc holds.
//     - On release, order continues without loss or duplication.
//  3. redirect_valid=1, redirect_pc=40 while queue full and id_ready=1:
//     - Next cycle id_valid=0.
//     - Cycle after: id_pc=40.
//     - No stale entry ever appears.
//  4. pc at 2^ADDR_W-1 with ADDR_W=4: fetched sequence is 15 then 0.
//  5. rstn=0 for one cycle mid-stream: next cycle id_valid=0 and pc=RESET_PC.
//  6. FETCH_PERF_EN: 10 pushes and 3 starved cycles -> perf_fetched=10, perf_bubbles=3.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// core_pkg: fetch-stage defaults and the {pc, inst} queue entry type.
package core_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
    localparam logic [31:0] INST_NOP = 32'h0;
    // pc is held at the widest supported address; narrower PCs are zero-extended
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: imem read port, redirect and decode handshake of the fetch stage.
interface inst_fetch_if #(parameter int ADDR_W = core_pkg::DEF_ADDR_W);
    logic [ADDR_W-1:0] imem_ra;
    logic [31:0] imem_rd;
    logic redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic id_ready;
    logic id_valid;
    logic [31:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    modport master (
        output imem_ra, id_valid, id_inst, id_pc,
        input imem_rd, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input imem_ra, id_valid, id_inst, id_pc,
        output imem_rd, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch entries; flush beats push, head reads as zero when empty.
module fetch_queue import core_pkg::*; #(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rstn,
    input logic push,
    input logic pop,
    input logic flush,
    input fetch_entry_t din,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t head
);
    localparam int PW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    assign head = (count != '0) ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and fetch queue between the combinational imem and decode.
// Optional FETCH_PERF_EN adds saturating perf_fetched/perf_bubbles counters.
module inst_fetch import core_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rstn,
    inst_fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0] count;
    fetch_entry_t head, din;
    logic pop, push;
    assign bus.imem_ra = pc;
    assign bus.id_valid = count != '0;
    assign bus.id_inst = head.inst;
    assign bus.id_pc = head.pc[ADDR_W-1:0];
    assign pop = bus.id_valid & bus.id_ready;
    // a full queue still accepts a fetch when decode frees the head this cycle
    assign push = !bus.redirect_valid & (count != FULL | pop);
    assign din = '{pc: DEF_ADDR_W'(pc), inst: bus.imem_rd};
    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk(clk),
        .rstn(rstn),
        .push(push),
        .pop(pop),
        .flush(bus.redirect_valid),
        .din(din),
        .count(count),
        .head(head)
    );
    always_ff @(posedge clk) begin
        if (!rstn) pc <= RESET_PC;
        else if (bus.redirect_valid) pc <= bus.redirect_pc;
        else if (push) pc <= pc + 1'b1;
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (push && perf_fetched != '1) perf_fetched <= perf_fetched + 1'b1;
            if (!bus.id_valid && !bus.redirect_valid && perf_bubbles != '1)
                perf_bubbles <= perf_bubbles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed + random fetch bench; imem model returns 32'h1000+addr,
// a scoreboard of expected PCs is refilled on every reset/redirect and drained on each pop.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rstn;
    int total = 0;
    int bad = 0;
    logic [31:0] sb [$];
    inst_fetch_if #(.ADDR_W(32)) bus ();
    inst_fetch_if #(.ADDR_W(4)) bus4 ();
`ifdef FETCH_PERF_EN
    logic [31:0] pf, pb, pf4, pb4;
`endif
    always #5 clk = ~clk;
    assign bus.imem_rd = 32'h1000 + bus.imem_ra;
    assign bus4.imem_rd = 32'h1000 + 32'(bus4.imem_ra);
    inst_fetch #(.ADDR_W(32), .RESET_PC(32'd0), .DEPTH(2)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(pf),
        .perf_bubbles(pb)
`endif
    );
    inst_fetch #(.ADDR_W(4), .RESET_PC(4'd0), .DEPTH(2)) dut4 (
        .clk(clk),
        .rstn(rstn),
        .bus(bus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(pf4),
        .perf_bubbles(pb4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // check the presented head against the scoreboard, drive one cycle of inputs, step
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.id_ready = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        if (bus.id_valid) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                chk("sb_pc", 64'(bus.id_pc), 64'(sb[0]));
                chk("sb_inst", 64'(bus.id_inst), 64'(32'h1000 + sb[0]));
                if (rdy && !rv) void'(sb.pop_front());
            end
        end
        if (rv) begin
            sb.delete();
            for (int i = 0; i < 64; i++) sb.push_back(rpc + 32'(i));
        end
        @(posedge clk);
        #1;
    endtask

    // reset is asserted together with a redirect to show that reset wins
    task automatic do_reset();
        rstn = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd99;
        bus.id_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_inst", 64'(bus.id_inst), 64'd0);
        chk("rst_pc", 64'(bus.id_pc), 64'd0);
        chk("rst_ra", 64'(bus.imem_ra), 64'd0);
        rstn = 1'b1;
        bus.redirect_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back(32'(i));
    endtask

    initial begin
        logic [3:0] e4;
        rstn = 1'b0;
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus4.id_ready = 1'b1;
        bus4.redirect_valid = 1'b0;
        bus4.redirect_pc = '0;
        @(posedge clk);
        #1;
        do_reset();
        // streaming with decode always ready
        repeat (8) begin
            cyc(1'b1, 1'b0, 32'd0);
            chk("t1_valid", 64'(bus.id_valid), 64'd1);
        end
        // mid-stream reset
        do_reset();
        // decode stall from reset: queue fills, pc parks at RESET_PC+DEPTH
        repeat (5) begin
            cyc(1'b0, 1'b0, 32'd0);
            chk("t2_hold_pc", 64'(bus.id_pc), 64'd0);
        end
        chk("t2_ra", 64'(bus.imem_ra), 64'd2);
        repeat (8) cyc(1'b1, 1'b0, 32'd0);
        // redirect while full
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'd40);
        chk("t3_bubble", 64'(bus.id_valid), 64'd0);
        chk("t3_ra", 64'(bus.imem_ra), 64'd40);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t3_valid", 64'(bus.id_valid), 64'd1);
        chk("t3_pc40", 64'(bus.id_pc), 64'd40);
        chk("t3_inst40", 64'(bus.id_inst), 64'h1028);
        repeat (6) cyc(1'b1, 1'b0, 32'd0);
        // random back-pressure and redirects
        repeat (80) cyc(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom);
        // narrow PC wraps 15 -> 0
        bus4.redirect_valid = 1'b1;
        bus4.redirect_pc = 4'd14;
        @(posedge clk);
        #1;
        bus4.redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            e4 = 4'(14 + i);
            chk("t4_pc", 64'(bus4.id_pc), 64'(e4));
            chk("t4_inst", 64'(bus4.id_inst), 64'(32'h1000 + 32'(e4)));
        end
        // 10 pushes, 3 empty non-redirect cycles
        do_reset();
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'd100);
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'd200);
        cyc(1'b1, 1'b0, 32'd0);
        repeat (7) cyc(1'b1, 1'b0, 32'd0);
`ifdef FETCH_PERF_EN
        chk("t6_fetched", 64'(pf), 64'd10);
        chk("t6_bubbles", 64'(pb), 64'd3);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
